// File: rtl/simple_phase_seq.sv
// Instruction-phase sequencer: walks the CPU datapath through FETCH, DECODE,
// EXECUTE and WRITEBACK with memory handshake, run/step/halt control and stall timeout.
module simple_phase_seq #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             is_mem,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [1:0]       phase,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // The stall that brings the wait count up to MAX_WAIT is the one that aborts.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           state_reg, state_next;
  logic             step_mode_reg, step_mode_next;
  logic             halt_pend_reg, halt_pend_next;
  logic             timeout_reg, timeout_next;
  logic [7:0]       wait_reg, wait_next;
  logic [CNT_W-1:0] retired_reg, retired_next;

  logic             stall;
  logic             wait_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      step_mode_reg <= 1'b0;
      halt_pend_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      wait_reg      <= 8'd0;
      retired_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      step_mode_reg <= step_mode_next;
      halt_pend_reg <= halt_pend_next;
      timeout_reg   <= timeout_next;
      wait_reg      <= wait_next;
      retired_reg   <= retired_next;
    end
  end

  // Outputs decoded from the state register; strobes also look at the handshake.
  always_comb begin
    mem_req   = 1'b0;
    phase     = 2'd0;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    wb_en     = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        phase    = 2'd0;
        mem_req  = 1'b1;
        fetch_en = mem_ready;
      end
      ST_DECODE: begin
        phase     = 2'd1;
        decode_en = 1'b1;
      end
      ST_EXEC: begin
        phase   = 2'd2;
        mem_req = is_mem;
        exec_en = !is_mem || mem_ready;
      end
      ST_WB: begin
        phase = 2'd3;
        wb_en = 1'b1;
      end
      default: begin
        phase = 2'd0;
      end
    endcase
  end

  assign stall    = mem_req && !mem_ready;
  assign wait_hit = stall && (wait_reg == WAIT_LAST);

  always_comb begin
    state_next     = state_reg;
    step_mode_next = step_mode_reg;
    halt_pend_next = halt_pend_reg;
    timeout_next   = timeout_reg;
    retired_next   = retired_reg;

    case (state_reg)
      ST_IDLE: begin
        if (!timeout_reg) begin
          if (run) begin
            state_next     = ST_FETCH;
            step_mode_next = 1'b0;
          end else if (step) begin
            state_next     = ST_FETCH;
            step_mode_next = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (mem_ready) begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_en) begin
          state_next     = ST_WB;
          halt_pend_next = halt_req;
        end
      end
      ST_WB: begin
        retired_next = retired_reg + CNT_W'(1);
        if (halt_pend_reg || step_mode_reg || !run) begin
          state_next     = ST_IDLE;
          halt_pend_next = 1'b0;
          step_mode_next = 1'b0;
        end else begin
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A memory stall that runs too long abandons the instruction uncounted.
    if (wait_hit) begin
      state_next     = ST_IDLE;
      timeout_next   = 1'b1;
      step_mode_next = 1'b0;
      halt_pend_next = 1'b0;
    end
  end

  always_comb begin
    wait_next = 8'd0;
    if (stall && (state_next == state_reg)) begin
      wait_next = wait_reg + 8'd1;
    end
  end

  assign halted  = (state_reg == ST_IDLE);
  assign timeout = timeout_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_simple_phase_seq.sv
// Bench for simple_phase_seq: per-cycle comparison against a phase-count model
// plus directed scenarios with hand-computed expectations.
module tb_simple_phase_seq;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             run = 1'b0;
  logic             step = 1'b0;
  logic             halt_req = 1'b0;
  logic             is_mem = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req;
  logic [1:0]       phase;
  logic             fetch_en, decode_en, exec_en, wb_en;
  logic             halted, timeout;
  logic [CNT_W-1:0] retired;

  simple_phase_seq #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .is_mem(is_mem), .mem_ready(mem_ready), .mem_req(mem_req), .phase(phase),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
    .halted(halted), .timeout(timeout), .retired(retired)
  );

  int checks = 0;
  int errors = 0;

  // Model: busy flag, phase number 0..3, consecutive-stall count, mode flags.
  bit m_valid = 0, m_busy = 0, m_single = 0, m_hpend = 0, m_timeout = 0;
  int m_ph = 0, m_wait = 0, m_retired = 0;

  // Tallies over a scenario window.
  bit tally_on = 0, phase_seq_on = 0;
  int cur_c = 0;
  int n_fetch, n_decode, n_exec, n_wb, n_req, n_multi, n_phase_bad, fetch_at, exec_at;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_memreq();
    return m_busy && (m_ph == 0 || (m_ph == 2 && is_mem));
  endfunction

  task automatic model_check();
    if (!m_valid) return;
    chk("phase",     32'(phase),     m_busy ? 32'(m_ph) : 32'd0);
    chk("mem_req",   32'(mem_req),   32'(m_memreq()));
    chk("fetch_en",  32'(fetch_en),  32'(m_busy && m_ph == 0 && mem_ready));
    chk("decode_en", 32'(decode_en), 32'(m_busy && m_ph == 1));
    chk("exec_en",   32'(exec_en),   32'(m_busy && m_ph == 2 && (!is_mem || mem_ready)));
    chk("wb_en",     32'(wb_en),     32'(m_busy && m_ph == 3));
    chk("halted",    32'(halted),    32'(!m_busy));
    chk("timeout",   32'(timeout),   32'(m_timeout));
    chk("retired",   32'(retired),   32'(m_retired));
  endtask

  task automatic model_step();
    bit stall, done;
    if (reset) begin
      m_valid = 1; m_busy = 0; m_ph = 0; m_wait = 0;
      m_single = 0; m_hpend = 0; m_timeout = 0; m_retired = 0;
    end else if (!m_valid) begin
      // nothing known yet
    end else if (!m_busy) begin
      if (!m_timeout && (run || step)) begin
        m_busy = 1; m_ph = 0; m_single = !run;
      end
    end else begin
      stall = m_memreq() && !mem_ready;
      case (m_ph)
        0: done = mem_ready;
        2: done = !is_mem || mem_ready;
        default: done = 1;
      endcase
      if (stall) begin
        m_wait++;
        if (m_wait == MAX_WAIT) begin
          m_busy = 0; m_timeout = 1; m_wait = 0; m_single = 0; m_hpend = 0;
        end
      end else if (done) begin
        m_wait = 0;
        if (m_ph == 2) m_hpend = halt_req;
        if (m_ph == 3) begin
          m_retired = (m_retired + 1) % (1 << CNT_W);
          if (m_hpend || m_single || !run) begin
            m_busy = 0; m_hpend = 0; m_single = 0;
          end else begin
            m_ph = 0;
          end
        end else begin
          m_ph++;
        end
      end
    end
  endtask

  task automatic clear_tally();
    n_fetch = 0; n_decode = 0; n_exec = 0; n_wb = 0; n_req = 0;
    n_multi = 0; n_phase_bad = 0; fetch_at = -1; exec_at = -1;
  endtask

  task automatic tally();
    if (!tally_on) return;
    if (fetch_en)  begin n_fetch++; fetch_at = cur_c; end
    if (decode_en) n_decode++;
    if (exec_en)   begin n_exec++; exec_at = cur_c; end
    if (wb_en)     n_wb++;
    if (mem_req)   n_req++;
    if (!halted && $countones({fetch_en, decode_en, exec_en, wb_en}) != 1) n_multi++;
    if (phase_seq_on && cur_c >= 1 && int'(phase) != (cur_c - 1) % 4) n_phase_bad++;
  endtask

  // One clock: compare mid-cycle, advance model on the edge, settle.
  task automatic cyc();
    @(negedge clk);
    model_check();
    tally();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; run = 0; step = 0; halt_req = 0; is_mem = 0; mem_ready = 0;
    cyc();
    cyc();
    reset = 0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    chk("idle_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    clear_tally();
    do_reset();
    chk("rst_halted",  32'(halted),  32'd1);
    chk("rst_phase",   32'(phase),   32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);

    // Free run, no memory waits: 10 instructions in 40 busy cycles.
    run = 1; mem_ready = 1; is_mem = 0;
    clear_tally(); tally_on = 1; phase_seq_on = 1;
    for (int c = 0; c <= 40; c++) begin
      cur_c = c;
      cyc();
    end
    tally_on = 0; phase_seq_on = 0;
    chk("free_retired", 32'(retired), 32'd10);
    chk("free_fetch",   32'(n_fetch), 32'd10);
    chk("free_decode",  32'(n_decode), 32'd10);
    chk("free_exec",    32'(n_exec), 32'd10);
    chk("free_wb",      32'(n_wb), 32'd10);
    chk("free_onehot",  32'(n_multi), 32'd0);
    chk("free_phases",  32'(n_phase_bad), 32'd0);
    run = 0;
    wait_idle(10);
    chk("free_stop_retired", 32'(retired), 32'd11);

    // Single step, with a second step pulse during EXEC that must be ignored.
    do_reset();
    mem_ready = 1; step = 1;
    cyc();
    step = 0;
    cyc();
    cyc();
    chk("step_exec_phase", 32'(phase), 32'd2);
    step = 1;
    cyc();
    step = 0;
    chk("step_wb_phase", 32'(phase), 32'd3);
    chk("step_wb_halted", 32'(halted), 32'd0);
    cyc();
    chk("step_halted", 32'(halted), 32'd1);
    chk("step_retired", 32'(retired), 32'd1);
    cyc();
    cyc();
    chk("step_ignored_halted", 32'(halted), 32'd1);
    chk("step_ignored_retired", 32'(retired), 32'd1);

    // Memory waits: 3 stalls in FETCH, 5 in EXEC, 12-cycle instruction.
    do_reset();
    is_mem = 1; step = 1;
    cyc();
    step = 0;
    clear_tally(); tally_on = 1;
    for (int c = 1; c <= 12; c++) begin
      cur_c = c;
      mem_ready = (c == 4 || c == 11);
      cyc();
    end
    tally_on = 0;
    chk("mem_req_cycles", 32'(n_req), 32'd10);
    chk("mem_fetch_cnt",  32'(n_fetch), 32'd1);
    chk("mem_exec_cnt",   32'(n_exec), 32'd1);
    chk("mem_fetch_at",   32'(fetch_at), 32'd4);
    chk("mem_exec_at",    32'(exec_at), 32'd11);
    chk("mem_halted",     32'(halted), 32'd1);
    chk("mem_retired",    32'(retired), 32'd1);

    // Halt request on the third instruction's EXEC while run stays high.
    do_reset();
    run = 1; mem_ready = 1;
    for (int c = 0; c <= 12; c++) begin
      halt_req = (c == 11);
      cyc();
    end
    chk("halt_halted",  32'(halted), 32'd1);
    chk("halt_retired", 32'(retired), 32'd3);
    chk("halt_timeout", 32'(timeout), 32'd0);
    run = 0; halt_req = 0;
    cyc();
    chk("halt_stays", 32'(halted), 32'd1);

    // Timeout: memory never ready in FETCH.
    do_reset();
    run = 1; mem_ready = 0;
    for (int c = 0; c <= 14; c++) cyc();
    chk("to_before_req",    32'(mem_req), 32'd1);
    chk("to_before_halted", 32'(halted), 32'd0);
    cyc();
    chk("to_halted",  32'(halted), 32'd1);
    chk("to_timeout", 32'(timeout), 32'd1);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    chk("to_retired", 32'(retired), 32'd0);
    mem_ready = 1; step = 1;
    for (int c = 0; c < 5; c++) cyc();
    chk("to_run_ignored", 32'(halted), 32'd1);
    run = 0; step = 0;
    reset = 1;
    cyc();
    reset = 0;
    chk("to_cleared", 32'(timeout), 32'd0);

    // Reset in the middle of the third instruction's EXEC.
    do_reset();
    run = 1; mem_ready = 1;
    for (int c = 0; c <= 10; c++) cyc();
    chk("mid_exec_phase",   32'(phase), 32'd2);
    chk("mid_exec_retired", 32'(retired), 32'd2);
    reset = 1;
    cyc();
    reset = 0; run = 0;
    chk("mid_rst_phase",   32'(phase), 32'd0);
    chk("mid_rst_halted",  32'(halted), 32'd1);
    chk("mid_rst_req",     32'(mem_req), 32'd0);
    chk("mid_rst_strobes", 32'({fetch_en, decode_en, exec_en, wb_en}), 32'd0);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    chk("mid_rst_timeout", 32'(timeout), 32'd0);

    // Counter wrap with a 4-bit count: 17 instructions leave 1.
    run = 1; mem_ready = 1; is_mem = 0;
    for (int c = 0; c <= 68; c++) cyc();
    chk("wrap_retired", 32'(retired), 32'd1);
    run = 0;
    wait_idle(8);
    chk("wrap_final", 32'(retired), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
